csel_adder_pipe: RTL and testbench
==================================

Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor for the multiplier datapath. Successor to the fixed 5-bit carry-select adder.
- Operands are split into NBLK = WIDTH/BLK blocks. For each block, both carry-in hypotheses (0 and 1) are computed, and the real carry then selects the result.
- One pipeline register sits per block boundary, so the carry-select chain is cut into NBLK stages.
- Valid/ready handshake on both sides with full backpressure. Add/subtract mode is carried per transaction.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be an integer multiple of BLK.
- BLK, 4, carry-select block width in bits; 1 <= BLK <= WIDTH. NBLK = WIDTH/BLK is the pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts a transaction this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1):
  - All stage valid bits clear; out_valid=0; sum=0, cout=0, ovf=0.
  - in_ready follows its combinational definition, so in_ready=1 while the pipeline is empty.
  - Data registers clear to 0.
- Global stall: adv = ~out_valid | out_ready; in_ready = adv.
  - When adv=0, every stage register (valid and data) holds.
  - When adv=1, all stages shift one position on the clock edge.
  - Bubbles are not compressed internally.
- Transfer rules:
  - Input transfer occurs on an edge where in_valid & in_ready.
  - Output transfer occurs on an edge where out_valid & out_ready.
  - If in_valid=0 while adv=1, a bubble (valid=0) enters stage 1.
- Stage k (k = 0..NBLK-1) processes bits [k*BLK +: BLK]:
  - Effective B is b ^ {WIDTH{sub}}; effective carry-in to block 0 is sub ? 1 : cin.
  - Combinationally, each stage forms sum0/c0 (carry-in 0) and sum1/c1 (carry-in 1) for its block.
  - It selects using the registered carry from stage k-1 (stage 0 uses the effective carry-in).
  - Selection is per bit, using the same chained-carry select as the existing carry-select adder: each bit's carry picks the next bit's sum/carry pair.
- Skew registers:
  - Unprocessed upper operand bits and the sub flag travel with the transaction.
  - Already-computed lower sum bits accumulate with it.
- Final stage:
  - Registers the full sum, cout = carry out of block NBLK-1, and ovf = c(WIDTH-1 into MSB) ^ cout.
- Latency and throughput:
  - Latency is NBLK advancing edges: a transaction accepted on edge t appears with out_valid=1 after edge t+NBLK-1, provided no stalls occur.
  - Throughput is 1 transaction per cycle while out_ready=1.
- Holding and ordering:
  - While out_valid=1 & out_ready=0, sum/cout/ovf are held stable and in_ready=0.
  - Transactions leave in acceptance order.
- Special cases:
  - NBLK=1 gives a single registered stage with latency 1.
  - BLK=WIDTH is legal.
  - Simultaneous input and output transfer on the same edge is legal and is the normal streaming case.
- Reset mid-operation: all in-flight transactions are discarded, out_valid drops immediately (asynchronously), and no stale result ever appears after reset release.
- Arithmetic: modulo 2^WIDTH. Every bit of sum, cout and ovf must equal the reference a + b_eff + cin_eff for all inputs.

Test Plan (WIDTH=16, BLK=4, NBLK=4):
- Reset, then a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → exactly 4 edges later out_valid=1, sum=0x0000, cout=1, ovf=0.
- sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. Then sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- sub=0, a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1 (carry ripples across all 4 blocks via the select chain).
- Stream 20 back-to-back random transactions with out_ready=1 and in_valid held high → in_ready stays 1, 20 consecutive out_valid cycles, results in order and matching the model.
- Fill the pipeline with 4 transactions, then hold out_ready=0 for 5 cycles → in_ready=0, sum held unchanged. Release out_ready → remaining results drain in order with no loss or duplication.
- Accept 3 transactions, assert rst for 1 cycle mid-flight → out_valid=0 immediately, no output for those transactions after release. A fresh 0x1234+0x1111 then gives 0x2345 after 4 edges.

Source files
------------

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor, one register per BLK-bit block.
// Upper operand bits travel with each transaction; lower sum bits accumulate.
module csel_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK;
    localparam int NSK  = (NBLK > 1) ? NBLK - 1 : 1;

    logic             adv;
    logic [NBLK-1:0]  v_q;
    logic [WIDTH-1:0] a_q [NSK];
    logic [WIDTH-1:0] b_q [NSK];
    logic [WIDTH-1:0] s_q [NBLK];
    logic             c_q [NBLK];
    logic             ovf_q;

    logic [WIDTH-1:0] a_in [NBLK];
    logic [WIDTH-1:0] b_in [NBLK];
    logic [WIDTH-1:0] s_in [NBLK];
    logic             c_in [NBLK];
    logic [WIDTH-1:0] s_nx [NBLK];
    logic             c_nx [NBLK];
    logic             cmsb;

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NBLK-1];
    assign sum       = s_q[NBLK-1];
    assign cout      = c_q[NBLK-1];
    assign ovf       = ovf_q;

    // Per-bit chained select: the running carry picks each bit's sum/carry pair.
    always_comb begin
        cmsb = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            logic c;
            logic [WIDTH-1:0] s;
            if (k == 0) begin
                a_in[k] = a;
                b_in[k] = b ^ {WIDTH{sub}};
                s_in[k] = '0;
                c_in[k] = sub | cin;
            end else begin
                a_in[k] = a_q[(k > 0) ? k - 1 : 0];
                b_in[k] = b_q[(k > 0) ? k - 1 : 0];
                s_in[k] = s_q[(k > 0) ? k - 1 : 0];
                c_in[k] = c_q[(k > 0) ? k - 1 : 0];
            end
            c = c_in[k];
            s = s_in[k];
            for (int j = 0; j < BLK; j++) begin
                int idx;
                logic p, g, t;
                idx = k * BLK + j;
                p = a_in[k][idx] ^ b_in[k][idx];
                g = a_in[k][idx] & b_in[k][idx];
                t = a_in[k][idx] | b_in[k][idx];
                s[idx] = c ? ~p : p;
                if (idx == WIDTH - 1)
                    cmsb = c;
                c = c ? t : g;
            end
            s_nx[k] = s;
            c_nx[k] = c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSK; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k < NBLK; k++) begin
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < NBLK; k++)
                v_q[k] <= v_q[k-1];
            for (int k = 0; k < NBLK - 1; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
            end
            for (int k = 0; k < NBLK; k++) begin
                s_q[k] <= s_nx[k];
                c_q[k] <= c_nx[k];
            end
            ovf_q <= cmsb ^ c_nx[NBLK-1];
        end
    end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed bench for csel_adder_pipe at WIDTH=16, BLK=4.
module tb_csel_adder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] q [$];

    csel_adder_pipe #(.WIDTH(16), .BLK(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {cout, ovf, sum} from a plain 17-bit addition
    function automatic logic [17:0] model(input logic [15:0] x,
            input logic [15:0] y, input logic ci, input logic sb);
        logic [15:0] be;
        logic        ce;
        logic [16:0] r;
        logic [15:0] lo;
        be = sb ? ~y : y;
        ce = sb ? 1'b1 : ci;
        r  = {1'b0, x} + {1'b0, be} + {16'd0, ce};
        lo = {1'b0, x[14:0]} + {1'b0, be[14:0]} + {15'd0, ce};
        return {r[16], lo[15] ^ r[16], r[15:0]};
    endfunction

    task automatic single(input string tag, input logic [15:0] x,
            input logic [15:0] y, input logic ci, input logic sb,
            input logic [17:0] exp);
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, {14'd0, cout, ovf, sum}, {14'd0, exp});
        tick();
    endtask

    // One cycle of the streaming loop: score outputs/inputs, then advance
    task automatic step(input string tag);
        if (out_valid && out_ready) begin
            if (q.size() == 0)
                chk({tag, "_extra"}, 32'd1, 32'd0);
            else
                chk({tag, "_res"}, {14'd0, cout, ovf, sum},
                    {14'd0, q.pop_front()});
        end
        if (in_valid && in_ready)
            q.push_back(model(a, b, cin, sub));
        tick();
    endtask

    initial begin
        int first, last, nout, rdy_bad, seen;
        logic [15:0] held;

        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outputs", {14'd0, cout, ovf, sum}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        single("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
        single("5_m_7", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        single("8000_m1", 16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        single("7fff_c1", 16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h8000});

        // back-to-back stream
        q.delete();
        out_ready = 1'b1;
        first = -1; last = -1; nout = 0; rdy_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) begin
                in_valid = 1'b1;
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                if (!in_ready) rdy_bad++;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                nout++;
            end
            step("stream");
            if (i >= 20 && q.size() == 0 && !out_valid) break;
        end
        chk("stream_in_ready", rdy_bad, 0);
        chk("stream_count", nout, 20);
        chk("stream_contig", last - first + 1, 20);
        chk("stream_drained", q.size(), 0);

        // fill then stall
        q.delete();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            a = 16'(16'h1111 * (k + 1)); b = 16'h0F0F;
            cin = 1'(k); sub = 1'(k >> 1);
            step("fill");
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        held = sum;
        chk("stall_first", {14'd0, cout, ovf, sum}, {14'd0, q[0]});
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_hold", {16'd0, sum}, {16'd0, held});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10 && q.size() > 0; k++)
            step("drain");
        chk("drain_empty", q.size(), 0);
        chk("drain_idle", {31'd0, out_valid}, 32'd0);

        // reset mid-flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a = 16'h0100 << k; b = 16'h0033; cin = 1'b0; sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_drop", {31'd0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("no_stale", seen, 0);
        single("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
